// File: rtl/sao_pkg.sv
// Shared types and constants for the SAO edge-offset statistics scan scheduler.
package sao_pkg;

   localparam int CTB_LOG2_DEF = 6;
   localparam int PIC_BITS_DEF = 13;
   localparam int WIN_W        = 2;
   localparam int WIN_H        = 2;

   typedef enum logic [1:0] {
      EO_0   = 2'd0,
      EO_90  = 2'd1,
      EO_135 = 2'd2,
      EO_45  = 2'd3
   } eo_class_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } sched_state_e;

   function automatic logic [1:0] pix_idx(input logic dy, input logic dx);
      return {dy, dx};
   endfunction

endpackage

// File: rtl/sao_eo_mask_gen.sv
// Per-class validity mask of one 2x2 window from its absolute origin and the picture size.
module sao_eo_mask_gen
   import sao_pkg::*;
#(
   parameter int PIC_BITS = PIC_BITS_DEF
)
(
   input  logic [PIC_BITS:0]   org_x,
   input  logic [PIC_BITS:0]   org_y,
   input  logic [PIC_BITS-1:0] pic_w,
   input  logic [PIC_BITS-1:0] pic_h,
   output logic [15:0]         eo_mask
);

   localparam int AW = PIC_BITS + 1;

   logic [AW-1:0] pw_s;
   logic [AW-1:0] ph_s;
   logic [AW-1:0] px_s;
   logic [AW-1:0] py_s;
   logic          in_s;
   logic          hok_s;
   logic          vok_s;
   logic [1:0]    p_s;

   assign pw_s = {1'b0, pic_w};
   assign ph_s = {1'b0, pic_h};

   // Test every window pixel against the picture and the presence of its EO neighbours.
   always_comb begin
      eo_mask = 16'h0000;
      px_s    = {AW{1'b0}};
      py_s    = {AW{1'b0}};
      in_s    = 1'b0;
      hok_s   = 1'b0;
      vok_s   = 1'b0;
      p_s     = 2'd0;
      for (int dy = 0; dy < WIN_H; dy++) begin
         for (int dx = 0; dx < WIN_W; dx++) begin
            px_s  = org_x + AW'(dx);
            py_s  = org_y + AW'(dy);
            p_s   = pix_idx(1'(dy), 1'(dx));
            in_s  = (px_s < pw_s) && (py_s < ph_s);
            hok_s = (px_s != {AW{1'b0}}) && ((px_s + AW'(1)) < pw_s);
            vok_s = (py_s != {AW{1'b0}}) && ((py_s + AW'(1)) < ph_s);
            eo_mask[{EO_0,   p_s}] = in_s & hok_s;
            eo_mask[{EO_90,  p_s}] = in_s & vok_s;
            eo_mask[{EO_135, p_s}] = in_s & hok_s & vok_s;
            eo_mask[{EO_45,  p_s}] = in_s & hok_s & vok_s;
         end
      end
   end

endmodule

// File: rtl/sao_stat_win_sched.sv
// Raster scan of one CTB in 2x2 windows, issuing registered descriptors with EO validity masks.
module sao_stat_win_sched
   import sao_pkg::*;
#(
   parameter int CTB_LOG2 = CTB_LOG2_DEF,
   parameter int PIC_BITS = PIC_BITS_DEF
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [PIC_BITS-1:0] ctb_x,
   input  logic [PIC_BITS-1:0] ctb_y,
   input  logic [PIC_BITS-1:0] pic_w,
   input  logic [PIC_BITS-1:0] pic_h,
   output logic                busy,
   output logic                done,
   output logic                win_valid,
   input  logic                win_ready,
   output logic [CTB_LOG2-1:0] win_x,
   output logic [CTB_LOG2-1:0] win_y,
   output logic                win_last,
   output logic [15:0]         eo_mask
);

   localparam int AW = PIC_BITS + 1;
   localparam logic [PIC_BITS-1:0] CTB_SIZE = PIC_BITS'(1 << CTB_LOG2);

   sched_state_e        state_r;
   logic [PIC_BITS-1:0] base_x_r;
   logic [PIC_BITS-1:0] base_y_r;
   logic [PIC_BITS-1:0] pic_w_r;
   logic [PIC_BITS-1:0] pic_h_r;
   logic [CTB_LOG2-1:0] lim_x_r;
   logic [CTB_LOG2-1:0] lim_y_r;

   logic                empty_s;
   logic [PIC_BITS-1:0] rem_w_s;
   logic [PIC_BITS-1:0] rem_h_s;
   logic [PIC_BITS-1:0] ext_w_s;
   logic [PIC_BITS-1:0] ext_h_s;
   logic [CTB_LOG2-1:0] in_lim_x_s;
   logic [CTB_LOG2-1:0] in_lim_y_s;
   logic [CTB_LOG2-1:0] cur_lim_x_s;
   logic [CTB_LOG2-1:0] cur_lim_y_s;
   logic [CTB_LOG2-1:0] nxt_x_s;
   logic [CTB_LOG2-1:0] nxt_y_s;
   logic                nxt_last_s;
   logic [AW-1:0]       org_x_s;
   logic [AW-1:0]       org_y_s;
   logic [PIC_BITS-1:0] dim_w_s;
   logic [PIC_BITS-1:0] dim_h_s;
   logic [15:0]         mask_s;

   // Clipped CTB extent from the live inputs; the limit is the top-left of the last (possibly straddling) window.
   always_comb begin
      empty_s = (ctb_x >= pic_w) || (ctb_y >= pic_h);
      rem_w_s = pic_w - ctb_x;
      rem_h_s = pic_h - ctb_y;
      if (rem_w_s > CTB_SIZE) begin
         ext_w_s = CTB_SIZE;
      end else begin
         ext_w_s = rem_w_s;
      end
      if (rem_h_s > CTB_SIZE) begin
         ext_h_s = CTB_SIZE;
      end else begin
         ext_h_s = rem_h_s;
      end
      in_lim_x_s = CTB_LOG2'(ext_w_s + PIC_BITS'(ext_w_s[0]) - PIC_BITS'(2));
      in_lim_y_s = CTB_LOG2'(ext_h_s + PIC_BITS'(ext_h_s[0]) - PIC_BITS'(2));
   end

   // Position of the window to present next; in IDLE that is the first window of the new CTB.
   always_comb begin
      if (state_r == IDLE) begin
         cur_lim_x_s = in_lim_x_s;
         cur_lim_y_s = in_lim_y_s;
         nxt_x_s     = {CTB_LOG2{1'b0}};
         nxt_y_s     = {CTB_LOG2{1'b0}};
         org_x_s     = {1'b0, ctb_x};
         org_y_s     = {1'b0, ctb_y};
         dim_w_s     = pic_w;
         dim_h_s     = pic_h;
      end else begin
         cur_lim_x_s = lim_x_r;
         cur_lim_y_s = lim_y_r;
         if (win_x == lim_x_r) begin
            nxt_x_s = {CTB_LOG2{1'b0}};
            nxt_y_s = win_y + CTB_LOG2'(2);
         end else begin
            nxt_x_s = win_x + CTB_LOG2'(2);
            nxt_y_s = win_y;
         end
         org_x_s = {1'b0, base_x_r} + AW'(nxt_x_s);
         org_y_s = {1'b0, base_y_r} + AW'(nxt_y_s);
         dim_w_s = pic_w_r;
         dim_h_s = pic_h_r;
      end
      nxt_last_s = (nxt_x_s == cur_lim_x_s) && (nxt_y_s == cur_lim_y_s);
   end

   sao_eo_mask_gen #(
      .PIC_BITS (PIC_BITS)
   ) u_mask (
      .org_x   (org_x_s),
      .org_y   (org_y_s),
      .pic_w   (dim_w_s),
      .pic_h   (dim_h_s),
      .eo_mask (mask_s)
   );

   // Scheduler FSM; descriptor and mask are loaded together so they always describe the same window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         win_valid <= 1'b0;
         win_last  <= 1'b0;
         win_x     <= {CTB_LOG2{1'b0}};
         win_y     <= {CTB_LOG2{1'b0}};
         eo_mask   <= 16'h0000;
         base_x_r  <= {PIC_BITS{1'b0}};
         base_y_r  <= {PIC_BITS{1'b0}};
         pic_w_r   <= {PIC_BITS{1'b0}};
         pic_h_r   <= {PIC_BITS{1'b0}};
         lim_x_r   <= {CTB_LOG2{1'b0}};
         lim_y_r   <= {CTB_LOG2{1'b0}};
      end else if (abort) begin
         state_r   <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         win_valid <= 1'b0;
         win_last  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  base_x_r <= ctb_x;
                  base_y_r <= ctb_y;
                  pic_w_r  <= pic_w;
                  pic_h_r  <= pic_h;
                  lim_x_r  <= in_lim_x_s;
                  lim_y_r  <= in_lim_y_s;
                  busy     <= 1'b1;
                  if (empty_s) begin
                     state_r <= DONE;
                     done    <= 1'b1;
                  end else begin
                     state_r   <= SCAN;
                     win_valid <= 1'b1;
                     win_x     <= nxt_x_s;
                     win_y     <= nxt_y_s;
                     win_last  <= nxt_last_s;
                     eo_mask   <= mask_s;
                  end
               end else begin
                  busy <= 1'b0;
               end
            end
            SCAN: begin
               if (win_valid && win_ready) begin
                  if (win_last) begin
                     state_r   <= DONE;
                     done      <= 1'b1;
                     win_valid <= 1'b0;
                     win_last  <= 1'b0;
                  end else begin
                     win_x    <= nxt_x_s;
                     win_y    <= nxt_y_s;
                     win_last <= nxt_last_s;
                     eo_mask  <= mask_s;
                  end
               end else begin
                  win_valid <= win_valid;
               end
            end
            DONE: begin
               state_r <= IDLE;
               done    <= 1'b0;
               busy    <= 1'b0;
            end
            default: begin
               state_r   <= IDLE;
               busy      <= 1'b0;
               done      <= 1'b0;
               win_valid <= 1'b0;
               win_last  <= 1'b0;
            end
         endcase
      end
   end

endmodule
